// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between a fixed-priority port 0 and a
// starvation-bounded port 1, capturing each result into a per-port response register.
module alu_arbiter #(
    parameter int unsigned MAXWAIT = 4,
    parameter int unsigned TAGW    = 5
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    input  logic [3:0]      req0_alucont,
    input  logic            req0_sltunsigned,
    input  logic [TAGW-1:0] req0_tag,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    input  logic [3:0]      req1_alucont,
    input  logic            req1_sltunsigned,
    input  logic [TAGW-1:0] req1_tag,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [31:0]     rsp0_result,
    output logic            rsp0_zero,
    output logic [TAGW-1:0] rsp0_tag,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [31:0]     rsp1_result,
    output logic            rsp1_zero,
    output logic [TAGW-1:0] rsp1_tag,

    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [3:0]      alu_cont,
    output logic            alu_sltunsigned,
    input  logic [31:0]     alu_result,
    input  logic            alu_zero
);

    localparam int unsigned CNTW = 4;
    localparam logic [CNTW-1:0] WAIT_MAX = CNTW'(MAXWAIT);

    logic            rsp0_valid_q, rsp0_valid_d;
    logic [31:0]     rsp0_result_q, rsp0_result_d;
    logic            rsp0_zero_q, rsp0_zero_d;
    logic [TAGW-1:0] rsp0_tag_q, rsp0_tag_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic [31:0]     rsp1_result_q, rsp1_result_d;
    logic            rsp1_zero_q, rsp1_zero_d;
    logic [TAGW-1:0] rsp1_tag_q, rsp1_tag_d;
    logic [CNTW-1:0] wait_q, wait_d;

    logic elig0, elig1, force1, grant0, grant1;

    // A port is eligible only when its response slot can take a new result.
    assign elig0  = ~reset & req0_valid & (~rsp0_valid_q | rsp0_ready);
    assign elig1  = ~reset & req1_valid & (~rsp1_valid_q | rsp1_ready);
    assign force1 = (wait_q == WAIT_MAX) & elig1;
    assign grant1 = force1 | (~elig0 & elig1);
    assign grant0 = elig0 & ~force1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Idle ALU is parked on port 0 operands with AND so its outputs stay deterministic.
    always_comb begin
        alu_a           = req0_a;
        alu_b           = req0_b;
        alu_cont        = 4'b0000;
        alu_sltunsigned = req0_sltunsigned;
        if (grant1) begin
            alu_a           = req1_a;
            alu_b           = req1_b;
            alu_cont        = req1_alucont;
            alu_sltunsigned = req1_sltunsigned;
        end else if (grant0) begin
            alu_cont = req0_alucont;
        end
    end

    always_comb begin
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp0_tag_d    = rsp0_tag_q;
        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
            rsp0_zero_d   = alu_zero;
            rsp0_tag_d    = req0_tag;
        end else if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end
    end

    always_comb begin
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        rsp1_tag_d    = rsp1_tag_q;
        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
            rsp1_zero_d   = alu_zero;
            rsp1_tag_d    = req1_tag;
        end else if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    // Denials count even when port 1 is blocked by its own full slot.
    always_comb begin
        wait_d = wait_q;
        if (~req1_valid | grant1) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp0_tag_q    <= '0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
            rsp1_tag_q    <= '0;
            wait_q        <= '0;
        end else begin
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp0_tag_q    <= rsp0_tag_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
            rsp1_tag_q    <= rsp1_tag_d;
            wait_q        <= wait_d;
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp0_tag    = rsp0_tag_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;
    assign rsp1_tag    = rsp1_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: external ALU model, cycle-level reference model with a
// per-cycle compare process, and directed scenarios with hand-computed results.
module tb_alu_arbiter;

    localparam int unsigned TAGW    = 5;
    localparam int unsigned MAXWAIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            req0_valid, req0_ready, req0_sltunsigned;
    logic [31:0]     req0_a, req0_b;
    logic [3:0]      req0_alucont;
    logic [TAGW-1:0] req0_tag;
    logic            req1_valid, req1_ready, req1_sltunsigned;
    logic [31:0]     req1_a, req1_b;
    logic [3:0]      req1_alucont;
    logic [TAGW-1:0] req1_tag;
    logic            rsp0_valid, rsp0_ready, rsp0_zero;
    logic [31:0]     rsp0_result;
    logic [TAGW-1:0] rsp0_tag;
    logic            rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0]     rsp1_result;
    logic [TAGW-1:0] rsp1_tag;
    logic [31:0]     alu_a, alu_b, alu_result;
    logic [3:0]      alu_cont;
    logic            alu_sltunsigned, alu_zero;

    alu_arbiter #(.MAXWAIT(MAXWAIT), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_alucont(req0_alucont), .req0_sltunsigned(req0_sltunsigned), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_alucont(req1_alucont), .req1_sltunsigned(req1_sltunsigned), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_tag(rsp1_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont), .alu_sltunsigned(alu_sltunsigned),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c, input logic s);
        logic [2:0] op;
        op = {c[3], c[1:0]};
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return c[2] ? a - b : a + b;
            3'b011:  return s ? 32'(a < b) : 32'($signed(a) < $signed(b));
            3'b100:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // Shared ALU seen by the block.
    always_comb begin
        alu_result = alu_ref(alu_a, alu_b, alu_cont, alu_sltunsigned);
        alu_zero   = (alu_a == alu_b);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: response slots and how many cycles port 1 has been denied.
    bit              m_ok = 1'b0;
    int              m_denied;
    bit              m_v0, m_v1, m_z0, m_z1;
    logic [31:0]     m_r0, m_r1;
    logic [TAGW-1:0] m_t0, m_t1;

    always @(negedge clk) begin : compare
        bit want0, want1, g0, g1;
        want0 = !reset && req0_valid && (!m_v0 || rsp0_ready);
        want1 = !reset && req1_valid && (!m_v1 || rsp1_ready);
        if (want1 && m_denied >= int'(MAXWAIT)) begin
            g1 = 1'b1; g0 = 1'b0;
        end else begin
            g0 = want0; g1 = want1 && !want0;
        end
        if (m_ok) begin
            chk("m_req0_ready", 32'(req0_ready), 32'(g0));
            chk("m_req1_ready", 32'(req1_ready), 32'(g1));
            chk("m_rsp0_valid", 32'(rsp0_valid), 32'(m_v0));
            chk("m_rsp1_valid", 32'(rsp1_valid), 32'(m_v1));
            chk("m_rsp0_result", rsp0_result, m_r0);
            chk("m_rsp1_result", rsp1_result, m_r1);
            chk("m_rsp0_zero", 32'(rsp0_zero), 32'(m_z0));
            chk("m_rsp1_zero", 32'(rsp1_zero), 32'(m_z1));
            chk("m_rsp0_tag", 32'(rsp0_tag), 32'(m_t0));
            chk("m_rsp1_tag", 32'(rsp1_tag), 32'(m_t1));
            chk("m_alu_a", alu_a, g1 ? req1_a : req0_a);
            chk("m_alu_b", alu_b, g1 ? req1_b : req0_b);
            chk("m_alu_cont", 32'(alu_cont), g1 ? 32'(req1_alucont) : (g0 ? 32'(req0_alucont) : 32'd0));
        end
        if (reset) begin
            m_ok = 1'b1; m_denied = 0;
            m_v0 = 1'b0; m_v1 = 1'b0; m_z0 = 1'b0; m_z1 = 1'b0;
            m_r0 = '0; m_r1 = '0; m_t0 = '0; m_t1 = '0;
        end else begin
            if (g0) begin
                m_v0 = 1'b1; m_t0 = req0_tag; m_z0 = (req0_a == req0_b);
                m_r0 = alu_ref(req0_a, req0_b, req0_alucont, req0_sltunsigned);
            end else if (rsp0_ready) begin
                m_v0 = 1'b0;
            end
            if (g1) begin
                m_v1 = 1'b1; m_t1 = req1_tag; m_z1 = (req1_a == req1_b);
                m_r1 = alu_ref(req1_a, req1_b, req1_alucont, req1_sltunsigned);
            end else if (rsp1_ready) begin
                m_v1 = 1'b0;
            end
            if (!req1_valid || g1) m_denied = 0;
            else if (m_denied < int'(MAXWAIT)) m_denied++;
        end
    end

    task automatic drv0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic s, input logic [TAGW-1:0] t);
        req0_valid = v; req0_a = a; req0_b = b; req0_alucont = c; req0_sltunsigned = s; req0_tag = t;
    endtask

    task automatic drv1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic s, input logic [TAGW-1:0] t);
        req1_valid = v; req1_a = a; req1_b = b; req1_alucont = c; req1_sltunsigned = s; req1_tag = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single port 0 operation with hand-computed result and zero flag.
    task automatic op0(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic s, input logic [31:0] er, input logic ez);
        tick();
        drv0(1'b1, a, b, c, s, 5'd2);
        @(negedge clk);
        chk({nm, "_ready"}, 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_result"}, rsp0_result, er);
        chk({nm, "_zero"}, 32'(rsp0_zero), 32'(ez));
    endtask

    initial begin
        int exp_g[10];
        int gseq[$];
        logic [TAGW-1:0] t1seq[$];
        int k0, k1;
        bit g0, g1, last_g1;

        reset = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drv0(1'b1, 32'd5, 32'd7, 4'b0010, 1'b0, 5'd3);
        drv1(1'b1, 32'd1, 32'd1, 4'b0010, 1'b0, 5'd1);

        // Two reset cycles with both requests valid.
        @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_rsp0_result", rsp0_result, 32'd0);
        chk("rst_rsp1_tag", 32'(rsp1_tag), 32'd0);
        tick();
        reset = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("exit_req0_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("add_result", rsp0_result, 32'd12);
        chk("add_zero", 32'(rsp0_zero), 32'd0);
        chk("add_tag", 32'(rsp0_tag), 32'd3);
        chk("add_valid", 32'(rsp0_valid), 32'd1);

        op0("sub",  32'd5, 32'd7, 4'b0110, 1'b0, 32'hFFFF_FFFE, 1'b0);
        op0("slt",  32'hFFFF_FFFF, 32'd1, 4'b0111, 1'b0, 32'd1, 1'b0);
        op0("sltu", 32'hFFFF_FFFF, 32'd1, 4'b0111, 1'b1, 32'd0, 1'b0);
        op0("eq",   32'd9, 32'd9, 4'b0010, 1'b0, 32'd18, 1'b1);
        op0("or",   32'h0000_00F0, 32'h0000_000F, 4'b0001, 1'b0, 32'h0000_00FF, 1'b0);

        // Contention: both ports valid every cycle, new payload after each accept.
        k0 = 0; k1 = 1; last_g1 = 1'b0;
        tick();
        drv0(1'b1, 32'(k0) * 32'd2, 32'd1, 4'b0010, 1'b0, TAGW'(k0));
        drv1(1'b1, 32'(k1) * 32'd3, 32'd1, 4'b0010, 1'b0, TAGW'(k1));
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (last_g1) t1seq.push_back(rsp1_tag);
            g0 = req0_ready; g1 = req1_ready;
            gseq.push_back(g1 ? 1 : (g0 ? 0 : 2));
            last_g1 = g1;
            tick();
            if (g0) begin
                k0++;
                drv0(1'b1, 32'(k0) * 32'd2, 32'd1, 4'b0010, 1'b0, TAGW'(k0));
            end
            if (g1) begin
                k1++;
                drv1(1'b1, 32'(k1) * 32'd3, 32'd1, 4'b0010, 1'b0, TAGW'(k1));
            end
        end
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) chk($sformatf("gseq%0d", i), 32'(gseq[i]), 32'(exp_g[i]));
        chk("p1_tag_count", 32'(t1seq.size()), 32'd2);
        if (t1seq.size() >= 2) begin
            chk("p1_tag0", 32'(t1seq[0]), 32'd1);
            chk("p1_tag1", 32'(t1seq[1]), 32'd2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Idle port 1: XOR granted immediately.
        tick();
        drv1(1'b1, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'b1000, 1'b0, 5'd6);
        @(negedge clk);
        chk("xor_req1_ready", 32'(req1_ready), 32'd1);
        chk("xor_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        rsp1_ready = 1'b0;
        @(negedge clk);
        chk("xor_result", rsp1_result, 32'h0F0F_F0F0);
        chk("xor_valid", 32'(rsp1_valid), 32'd1);

        // Backpressure on port 1 while port 0 keeps streaming.
        tick();
        drv1(1'b1, 32'd100, 32'd23, 4'b0010, 1'b0, 5'd7);
        drv0(1'b1, 32'd1, 32'd2, 4'b0010, 1'b0, 5'd9);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_req1_ready%0d", c), 32'(req1_ready), 32'd0);
            chk($sformatf("bp_hold%0d", c), rsp1_result, 32'h0F0F_F0F0);
            tick();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_forced_req1", 32'(req1_ready), 32'd1);
        chk("bp_forced_req0", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_new_result", rsp1_result, 32'd123);
        chk("bp_new_tag", 32'(rsp1_tag), 32'd7);
        chk("bp_valid", 32'(rsp1_valid), 32'd1);
        chk("bp_p0_resume", 32'(req0_ready), 32'd1);

        // Reset mid-operation with both slots full and port 1 starving.
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drv0(1'b1, 32'h0000_00FF, 32'h0000_000F, 4'b0000, 1'b0, 5'd4);
        drv1(1'b1, 32'h0000_0F00, 32'h0000_000F, 4'b0001, 1'b0, 5'd5);
        for (int c = 0; c < 6; c++) tick();
        @(negedge clk);
        chk("pre_rst_rsp0_valid", 32'(rsp0_valid), 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("in_rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("in_rst_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        reset = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("post_rst_rsp0_result", rsp0_result, 32'd0);
        chk("post_rst_req0_first", 32'(req0_ready), 32'd1);
        chk("post_rst_req1_held", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
